// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column drive, debounces presses and
// releases, and hands one code per keypress to a single-entry holding register.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [7:0] key_data,
    output logic       key_present,
    output logic       key_overflow,
    input  logic       key_ack
);

    // state    | meaning
    // SCAN     | dwell on each column, look for a pressed row at terminal count
    // DEBOUNCE | captured pattern must stay stable DEBOUNCE_CYCLES clocks
    // HELD     | key accepted and pushed once, column frozen until release
    // RELEASE  | rows must read all-clear DEBOUNCE_CYCLES clocks before rescanning
    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    localparam logic [23:0] DWELL_TC = 24'(SCAN_DIV - 1);
    localparam logic [23:0] DEB_TC   = 24'(DEBOUNCE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_row_meta;
    logic [3:0]  r_row_s;
    logic [23:0] r_cnt;
    logic [1:0]  r_col_idx;
    logic [3:0]  r_pattern;
    logic [3:0]  r_code;
    logic [3:0]  r_key;
    logic        r_present;
    logic        r_overflow;

    logic        w_idle;
    logic        w_match;
    logic        w_dwell_tc;
    logic        w_deb_tc;
    logic [1:0]  w_row_idx;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_rotate;
    logic        w_capture;
    logic        w_push;

    assign w_idle     = (r_row_s == 4'hF);
    assign w_match    = (r_row_s == r_pattern);
    assign w_dwell_tc = (r_cnt == DWELL_TC);
    assign w_deb_tc   = (r_cnt == DEB_TC);

    // Lowest-numbered low row wins when several keys share the column.
    always_comb begin
        w_row_idx = 2'd3;
        if (!r_row_s[0])      w_row_idx = 2'd0;
        else if (!r_row_s[1]) w_row_idx = 2'd1;
        else if (!r_row_s[2]) w_row_idx = 2'd2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_SCAN;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SCAN:     if (w_dwell_tc && !w_idle) w_next = S_DEBOUNCE;
            S_DEBOUNCE: if (!w_match)              w_next = S_SCAN;
                        else if (w_deb_tc)         w_next = S_HELD;
            S_HELD:     if (w_idle)                w_next = S_RELEASE;
            S_RELEASE:  if (!w_idle)               w_next = S_HELD;
                        else if (w_deb_tc)         w_next = S_SCAN;
            default:                               w_next = S_SCAN;
        endcase
    end

    always_comb begin
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        w_rotate  = 1'b0;
        w_capture = 1'b0;
        w_push    = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (w_dwell_tc) begin
                    w_cnt_clr = 1'b1;
                    w_rotate  = w_idle;
                    w_capture = !w_idle;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (!w_match || w_deb_tc) w_cnt_clr = 1'b1;
                else                      w_cnt_inc = 1'b1;
                w_push = w_match && w_deb_tc;
            end
            S_HELD: w_cnt_clr = 1'b1;
            S_RELEASE: begin
                if (!w_idle || w_deb_tc) w_cnt_clr = 1'b1;
                else                     w_cnt_inc = 1'b1;
                w_rotate = w_idle && w_deb_tc;
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
            r_cnt      <= '0;
            r_col_idx  <= 2'd0;
            r_pattern  <= 4'hF;
            r_code     <= 4'h0;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 24'd1;
            if (w_rotate) r_col_idx <= r_col_idx + 2'd1;
            if (w_capture) begin
                r_pattern <= r_row_s;
                r_code    <= {r_col_idx, w_row_idx};
            end
        end
    end

    // Single-entry holding register; an ack coinciding with a push replaces the entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key      <= 4'h0;
            r_present  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_push) begin
            if (!r_present || key_ack) begin
                r_key     <= r_code;
                r_present <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (key_ack && r_present) begin
            r_present  <= 1'b0;
            r_overflow <= 1'b0;
        end
    end

    assign col          = ~(4'b0001 << r_col_idx);
    assign key_data     = {4'b0000, r_key};
    assign key_present  = r_present;
    assign key_overflow = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a
// behavioural 4x4 keypad that pulls rows low for pressed keys in the driven column.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_ack;
    logic [3:0] col;
    logic [3:0] row;
    logic [7:0] key_data;
    logic       key_present;
    logic       key_overflow;

    logic [15:0] keys_down;
    logic        force_en;
    logic [3:0]  force_val;
    logic [3:0]  row_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        row_m = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && keys_down[c*4+r]) row_m[r] = 1'b0;
        row = force_en ? force_val : row_m;
    end

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .col(col), .row(row),
        .key_data(key_data), .key_present(key_present),
        .key_overflow(key_overflow), .key_ack(key_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_col_change(input int maxc, output int n);
        logic [3:0] c0;
        c0 = col;
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (col !== c0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_flag(input bit want_ovf, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if ((want_ovf ? key_overflow : key_present) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    function automatic int col_idx(input logic [3:0] c);
        case (c)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0; key_ack = 1'b0; keys_down = '0; force_en = 1'b0; force_val = 4'hF;
        repeat (3) tick();
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got %b exp 1110", col); end
        checks++; if (key_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", key_data); end
        checks++; if (key_present !== 1'b0) begin errors++; $display("FAIL reset_present got %b exp 0", key_present); end
        checks++; if (key_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", key_overflow); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_col;
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            checks++; if (col !== exp_col) begin errors++; $display("FAIL scan_col cycle %0d got %b exp %b", i, col, exp_col); end
            checks++; if (key_present !== 1'b0) begin errors++; $display("FAIL scan_present cycle %0d got %b exp 0", i, key_present); end
        end
    endtask

    task automatic test_press();
        int n;
        keys_down = 16'h0040;
        wait_flag(1'b0, 100, n);
        checks++; if (n < 0) begin errors++; $display("FAIL press_timeout got no key_present exp within 100"); end
        checks++; if (key_data !== 8'h06) begin errors++; $display("FAIL press_data got %h exp 06", key_data); end
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL press_col got %b exp 1101", col); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (col !== 4'b1101 || key_present !== 1'b1) begin
                errors++; $display("FAIL held_frozen got col %b present %b exp 1101 1", col, key_present);
            end
        end
        checks++; if (key_overflow !== 1'b0) begin errors++; $display("FAIL no_repeat got ovf %b exp 0", key_overflow); end
        keys_down = '0;
        wait_col_change(30, n);
        checks++; if (n < 10 || n > 12) begin errors++; $display("FAIL release_delay got %0d exp 10..12", n); end
        checks++; if (col !== 4'b1011) begin errors++; $display("FAIL release_col got %b exp 1011", col); end
        pulse_ack();
        checks++; if (key_present !== 1'b0) begin errors++; $display("FAIL ack_present got %b exp 0", key_present); end
    endtask

    task automatic test_glitch();
        int n;
        logic [3:0] col_e;
        wait_col_change(10, n);
        checks++; if (n < 0) begin errors++; $display("FAIL glitch_align got timeout exp rotation"); end
        col_e = col;
        tick();
        force_en = 1'b1; force_val = 4'b1110;
        repeat (3) tick();
        force_en = 1'b0;
        checks++; if (col !== col_e) begin errors++; $display("FAIL glitch_hold_col got %b exp %b", col, col_e); end
        wait_col_change(20, n);
        checks++; if (n != 7) begin errors++; $display("FAIL glitch_rescan got %0d exp 7", n); end
        repeat (20) tick();
        checks++; if (key_present !== 1'b0) begin errors++; $display("FAIL glitch_push got present %b exp 0", key_present); end
    endtask

    task automatic test_multi_key();
        int n;
        keys_down = 16'h0A00;
        wait_flag(1'b0, 100, n);
        checks++; if (n < 0) begin errors++; $display("FAIL multi_timeout got no key_present exp within 100"); end
        checks++; if (key_data !== 8'h09) begin errors++; $display("FAIL multi_data got %h exp 09", key_data); end
        keys_down = '0;
        wait_col_change(30, n);
        pulse_ack();
        checks++; if (key_present !== 1'b0) begin errors++; $display("FAIL multi_ack got %b exp 0", key_present); end
    endtask

    task automatic test_overflow();
        int n;
        keys_down = 16'h0040;
        wait_flag(1'b0, 100, n);
        checks++; if (key_data !== 8'h06) begin errors++; $display("FAIL ovf_first got %h exp 06", key_data); end
        keys_down = '0;
        wait_col_change(30, n);
        keys_down = 16'h2000;
        wait_flag(1'b1, 100, n);
        checks++; if (n < 0) begin errors++; $display("FAIL ovf_timeout got no overflow exp within 100"); end
        checks++; if (key_data !== 8'h06) begin errors++; $display("FAIL ovf_keep got %h exp 06", key_data); end
        checks++; if (key_present !== 1'b1) begin errors++; $display("FAIL ovf_present got %b exp 1", key_present); end
        keys_down = '0;
        wait_col_change(30, n);
    endtask

    task automatic test_back_to_back();
        int n;
        int c;
        logic [7:0] exp_code;
        wait_col_change(10, n);
        checks++; if (n < 0) begin errors++; $display("FAIL b2b_align got timeout exp rotation"); end
        c = (col_idx(col) + 1) % 4;
        exp_code = 8'(c * 4 + 1);
        keys_down = 16'(1 << (c * 4 + 1));
        repeat (15) tick();
        checks++; if (key_data !== 8'h06) begin errors++; $display("FAIL b2b_pre got %h exp 06", key_data); end
        pulse_ack();
        checks++; if (key_data !== exp_code) begin errors++; $display("FAIL b2b_data got %h exp %h", key_data, exp_code); end
        checks++; if (key_present !== 1'b1) begin errors++; $display("FAIL b2b_present got %b exp 1", key_present); end
        checks++; if (key_overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %b exp 1", key_overflow); end
        keys_down = '0;
        wait_col_change(30, n);
        pulse_ack();
        checks++; if (key_present !== 1'b0) begin errors++; $display("FAIL ack_clear_present got %b exp 0", key_present); end
        checks++; if (key_overflow !== 1'b0) begin errors++; $display("FAIL ack_clear_ovf got %b exp 0", key_overflow); end
    endtask

    task automatic test_reset_mid_debounce();
        int n;
        int c;
        keys_down = 16'h0040;
        wait_flag(1'b0, 100, n);
        keys_down = '0;
        wait_col_change(30, n);
        c = (col_idx(col) + 1) % 4;
        keys_down = 16'(1 << (c * 4 + 2));
        repeat (11) tick();
        reset = 1'b0;
        #1;
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rst_mid_col got %b exp 1110", col); end
        checks++; if (key_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", key_data); end
        checks++; if (key_present !== 1'b0) begin errors++; $display("FAIL rst_mid_present got %b exp 0", key_present); end
        keys_down = '0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL rst_first_rot got %b exp 1101", col); end
        repeat (40) tick();
        checks++; if (key_present !== 1'b0) begin errors++; $display("FAIL rst_no_push got %b exp 0", key_present); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press();
        test_glitch();
        test_multi_key();
        test_overflow();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL provide parameter SCAN_DIV, default 100000, giving clocks per column dwell (1 ms at 100 MHz); legal values are 2..2^24-1.
REQ-002 The module SHALL provide parameter DEBOUNCE_CYCLES, default 2000000, giving consecutive stable clocks required to accept a press or a release; legal values are 2..2^24-1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock, 100 MHz.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port col, output, 4 bits: active-low one-hot column drive to the keypad.
REQ-006 The module SHALL have port row, input, 4 bits: keypad rows, pulled up, so a pressed key in the driven column reads 0.
REQ-007 The module SHALL have port key_data, output, 8 bits: {4'b0, key code} of the oldest unread key.
REQ-008 The module SHALL have port key_present, output, 1 bit: key_data is valid and unread.
REQ-009 The module SHALL have port key_overflow, output, 1 bit: sticky flag, set when a key is lost because one is already pending.
REQ-010 The module SHALL have port key_ack, input, 1 bit: a one-clock pulse from the PicoBlaze input-port logic that consumes key_data.

Function
REQ-011 The module SHALL pass row through a 2-flop synchronizer (row_s); all decisions SHALL use row_s only.
REQ-012 The module SHALL implement a state machine with states SCAN, DEBOUNCE, HELD and RELEASE; the reset state SHALL be SCAN.
REQ-013 In SCAN, a dwell counter SHALL count 0..SCAN_DIV-1; at terminal count col SHALL rotate left 1110->1101->1011->0111->1110 and the counter SHALL clear.
REQ-014 At dwell terminal count in SCAN with row_s != 4'hF, the FSM SHALL go to DEBOUNCE without rotating col, capturing the column index c (0..3) and row_s.
REQ-015 In SCAN, the captured row index r SHALL be the lowest-numbered row bit that is 0 (multiple keys: lowest row wins).
REQ-016 The key code SHALL be 4*c + r, range 0..15, unsigned 4 bits.
REQ-017 In DEBOUNCE, the debounce counter SHALL increment each clock that row_s equals the captured pattern.
REQ-018 In DEBOUNCE, any mismatch SHALL clear the debounce counter and return the FSM to SCAN with the dwell counter cleared and col unchanged.
REQ-019 When the debounce counter reaches DEBOUNCE_CYCLES-1 with row_s still matching, the FSM SHALL enter HELD and issue a one-clock push of the code; key_present SHALL be visible on the following clock.
REQ-020 In HELD, col SHALL stay frozen; when row_s == 4'hF the FSM SHALL enter RELEASE with the counter cleared.
REQ-021 In RELEASE, the counter SHALL count consecutive clocks with row_s == 4'hF; any 0 bit SHALL clear the counter and return the FSM to HELD with no new push.
REQ-022 After DEBOUNCE_CYCLES consecutive clear clocks, the FSM SHALL go to SCAN, rotate col once and clear the dwell counter.
REQ-023 A held key SHALL produce exactly one push; there SHALL be no auto-repeat.
REQ-024 On a push with key_present=0, the holding register SHALL load key_data and set key_present=1.
REQ-025 On a push with key_present=1 and no key_ack in the same cycle, the holding register SHALL keep key_data and set key_overflow=1.
REQ-026 On a push and key_ack in the same cycle, the holding register SHALL load the new key_data, keep key_present=1 and leave key_overflow unchanged.
REQ-027 key_ack with key_present=1 and no push SHALL clear key_present and key_overflow on the next edge.
REQ-028 key_ack with key_present=0 SHALL be ignored.
REQ-029 Counters SHALL be 24-bit unsigned and SHALL never wrap; each SHALL clear at its terminal count or on a state change.

Reset
REQ-030 Asserting reset=0, at any time including mid-debounce, SHALL immediately force col=4'b1110, key_data=8'h00, key_present=0, key_overflow=0, FSM=SCAN, all counters to 0 and the synchronizer to 4'hF.
REQ-031 After reset=1, the first col rotation SHALL occur SCAN_DIV clocks later.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-032 The bench SHALL cover: no key pressed, release reset -> col cycles 1110,1101,1011,0111 every 4 clocks and key_present stays 0.
REQ-033 The bench SHALL cover: row[2] held low while col=1101 -> key_present rises with key_data=8'h06, col frozen at 1101 until release plus 8 clear clocks.
REQ-034 The bench SHALL cover: a 3-clock low glitch on row[0] -> return to SCAN and no push.
REQ-035 The bench SHALL cover: key 0x06 pending and unacked, then key 0x0D (col 0111, row 1) pressed -> key_data stays 8'h06, key_overflow=1; key_ack then clears both flags.
REQ-036 The bench SHALL cover: push coinciding with key_ack -> key_data takes the new code and key_present stays 1.
REQ-037 The bench SHALL cover: reset pulsed low during DEBOUNCE -> outputs at reset values immediately, and no push after reset=1.
